stopwatch_controller: RTL and testbench

- Sequencing controller for the stopwatch minutes/seconds counter.
- Turns three debounced user buttons (start/stop, clear, lap) into the counter's hold and reset controls.
- Generates the 1 Hz count enable from the system clock.
- Muxes live or lap-frozen time onto the display path.
- Sits between the button debouncers and the time counter / 7-segment driver.

---
 rtl/stopwatch_pkg.sv | 24 ++
 rtl/stopwatch_controller_btn_sync_edge.sv | 37 +++
 rtl/stopwatch_controller.sv | 190 +++++++++++++++++++
 tb/tb_stopwatch_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state type and time constants for the stopwatch controller
//
// Purpose : controller state enumeration, display time width and the 59:59
//           ceiling used by the optional autostop (STOPWATCH_AUTOSTOP_EN).
// Ports   : none (package).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  localparam int TIME_W  = 6;
  localparam int MAX_MIN = 59;
  localparam int MAX_SEC = 59;

  // RUN and LAP both advance the prescaler; only the display differs.
  function automatic logic is_counting(sw_state_t s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_controller_btn_sync_edge.sv
// rtl/stopwatch_controller_btn_sync_edge.sv - button synchroniser with rising-edge command pulse
//
// Purpose : brings one debounced, asynchronous button level into the clock
//           domain through two flops and emits a single-cycle pulse on the
//           synchronised rising edge. A held button yields one pulse only.
// Ports   : clock  in  system clock
//           reset  in  asynchronous active-high reset
//           btn    in  debounced button level (asynchronous)
//           pulse  out one-cycle command, valid in the cycle after the 2nd
//                      sampling flop goes high (consumed on the 3rd edge)
module btn_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_2_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_q <= 1'b0;
    end else begin
      sync_1   <= btn;
      sync_2   <= sync_1;
      sync_2_q <= sync_2;
    end
  end

  // Combinational from flops only, so the FSM samples it on the next edge.
  assign pulse = sync_2 & ~sync_2_q;

endmodule

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - stopwatch sequencing controller (buttons, 1 Hz enable, display mux)
//
// Purpose : turns start/stop, clear and lap buttons into hold/reset controls
//           for the external minutes/seconds counter, generates the per-second
//           count enable from a TICK_DIV prescaler and selects live or
//           lap-frozen time for the display.
//           Optional macro STOPWATCH_AUTOSTOP_EN: stop at 59:59 and lock out
//           start/stop until clear.
// Ports   : clock, reset          system clock, async active-high reset
//           btn_start_stop, btn_clear, btn_lap   debounced async buttons
//           minutes, seconds      live time from the counter
//           hold_count            low for one cycle per counted second
//           counter_reset         one-cycle counter clear pulse
//           disp_minutes, disp_seconds   registered display time
//           running               high in RUN and LAP
//           lap_active            high in LAP
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              btn_start_stop,
  input  logic              btn_clear,
  input  logic              btn_lap,
  input  logic [TIME_W-1:0] minutes,
  input  logic [TIME_W-1:0] seconds,
  output logic              hold_count,
  output logic              counter_reset,
  output logic [TIME_W-1:0] disp_minutes,
  output logic [TIME_W-1:0] disp_seconds,
  output logic              running,
  output logic              lap_active
);

  localparam int PW = $clog2(TICK_DIV);

  sw_state_t         state;
  logic [PW-1:0]     prescaler;
  logic [TIME_W-1:0] snap_minutes;
  logic [TIME_W-1:0] snap_seconds;
  logic              snap_valid;

  logic pulse_start_stop;
  logic pulse_clear;
  logic pulse_lap;

  logic cmd_clear;
  logic cmd_start_stop;
  logic cmd_lap;
  logic counting;
  logic at_term;
  logic leaving;
  logic term_ok;
  logic sat_hit;
  logic resume_blocked;

  btn_sync_edge u_sync_start_stop (
    .clock (clock),
    .reset (reset),
    .btn   (btn_start_stop),
    .pulse (pulse_start_stop)
  );

  btn_sync_edge u_sync_clear (
    .clock (clock),
    .reset (reset),
    .btn   (btn_clear),
    .pulse (pulse_clear)
  );

  btn_sync_edge u_sync_lap (
    .clock (clock),
    .reset (reset),
    .btn   (btn_lap),
    .pulse (pulse_lap)
  );

  // Coinciding commands: clear beats start/stop beats lap; losers are dropped.
  assign cmd_clear      = pulse_clear;
  assign cmd_start_stop = pulse_start_stop & ~pulse_clear;
  assign cmd_lap        = pulse_lap & ~pulse_clear & ~pulse_start_stop;

  assign counting = is_counting(state);
  assign at_term  = (prescaler == PW'(TICK_DIV - 1));
  // Leaving the counting states in the terminal cycle forfeits that tick.
  assign leaving  = counting & (cmd_clear | cmd_start_stop);
  assign term_ok  = counting & at_term & ~leaving;

`ifdef STOPWATCH_AUTOSTOP_EN
  logic saturated;
  assign sat_hit        = term_ok && (minutes == TIME_W'(MAX_MIN)) && (seconds == TIME_W'(MAX_SEC));
  assign resume_blocked = saturated;
`else
  assign sat_hit        = 1'b0;
  assign resume_blocked = 1'b0;
`endif

  // Derived from flops and the synchronised pulses only, so it is stable
  // well before the counter samples it.
  assign hold_count = ~(term_ok & ~sat_hit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      prescaler     <= '0;
      counter_reset <= 1'b0;
      running       <= 1'b0;
      lap_active    <= 1'b0;
      snap_minutes  <= '0;
      snap_seconds  <= '0;
      snap_valid    <= 1'b0;
      disp_minutes  <= '0;
      disp_seconds  <= '0;
`ifdef STOPWATCH_AUTOSTOP_EN
      saturated     <= 1'b0;
`endif
    end else begin
      counter_reset <= cmd_clear;
      disp_minutes  <= snap_valid ? snap_minutes : minutes;
      disp_seconds  <= snap_valid ? snap_seconds : seconds;

      if (cmd_clear) begin
        state        <= IDLE;
        prescaler    <= '0;
        running      <= 1'b0;
        lap_active   <= 1'b0;
        snap_minutes <= '0;
        snap_seconds <= '0;
        snap_valid   <= 1'b0;
`ifdef STOPWATCH_AUTOSTOP_EN
        saturated    <= 1'b0;
`endif
      end else begin
        // PAUSE keeps the prescaler so the sub-second fraction survives.
        if (counting) begin
          prescaler <= at_term ? '0 : prescaler + 1'b1;
        end

        if (sat_hit) begin
          state      <= PAUSE;
          running    <= 1'b0;
          lap_active <= 1'b0;
`ifdef STOPWATCH_AUTOSTOP_EN
          saturated  <= 1'b1;
`endif
        end else if (cmd_start_stop) begin
          unique case (state)
            IDLE: begin
              state   <= RUN;
              running <= 1'b1;
            end
            RUN, LAP: begin
              state      <= PAUSE;
              running    <= 1'b0;
              lap_active <= 1'b0;
            end
            PAUSE: begin
              if (!resume_blocked) begin
                // A held snapshot means the pause was entered from LAP.
                state      <= snap_valid ? LAP : RUN;
                running    <= 1'b1;
                lap_active <= snap_valid;
              end
            end
          endcase
        end else if (cmd_lap) begin
          unique case (state)
            RUN: begin
              state        <= LAP;
              lap_active   <= 1'b1;
              snap_valid   <= 1'b1;
              snap_minutes <= minutes;
              snap_seconds <= seconds;
            end
            LAP: begin
              state      <= RUN;
              lap_active <= 1'b0;
              snap_valid <= 1'b0;
            end
            PAUSE: snap_valid <= 1'b0;
            IDLE: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - scoreboard bench for stopwatch_controller with a behavioural model
module tb_stopwatch_controller;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
`ifdef STOPWATCH_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic       hold_count;
  logic       counter_reset;
  logic [5:0] disp_minutes;
  logic [5:0] disp_seconds;
  logic       running;
  logic       lap_active;

  stopwatch_controller #(.TICK_DIV(TD)) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .minutes        (minutes),
    .seconds        (seconds),
    .hold_count     (hold_count),
    .counter_reset  (counter_reset),
    .disp_minutes   (disp_minutes),
    .disp_seconds   (disp_seconds),
    .running        (running),
    .lap_active     (lap_active)
  );

  always #5 clock = ~clock;

  typedef struct {
    int hold;
    int crst;
    int run;
    int lap;
    int disp;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   dut_ticks = 0;
  int   crst_cnt = 0;

  // Behavioural model: time kept as total seconds, buttons as sample history.
  int       m_mode, m_frac, m_time, m_snap, m_disp;
  bit       m_snap_ok, m_sat, m_creset;
  bit       c_clr, c_ss, c_lap, c_tick, c_sat;
  bit [2:0] h0, h1, h2, lv;  // bit0 start_stop, bit1 clear, bit2 lap

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mmss(input int t);
    return (t / 60) * 100 + (t % 60);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_frac = 0; m_snap = 0; m_disp = 0;
    m_snap_ok = 0; m_sat = 0; m_creset = 0;
    c_clr = 0; c_ss = 0; c_lap = 0; c_tick = 0; c_sat = 0;
    h0 = '0; h1 = '0; h2 = '0; lv = '0;
  endtask

  task automatic drive_time();
    minutes = 6'(m_time / 60);
    seconds = 6'(m_time % 60);
  endtask

  task automatic edge_update();
    int old_time;
    bit counting;
    h2 = h1; h1 = h0; h0 = lv;
    old_time = m_time;
    if (m_creset) m_time = 0;
    else if (c_tick) m_time = (m_time + 1) % 3600;
    m_disp   = m_snap_ok ? m_snap : old_time;
    m_creset = c_clr;
    counting = (m_mode == M_RUN) || (m_mode == M_LAP);
    if (c_clr) begin
      m_mode = M_IDLE; m_frac = 0; m_snap = 0; m_snap_ok = 0; m_sat = 0;
    end else begin
      if (counting) m_frac = (m_frac + 1) % TD;
      if (c_sat) begin
        m_mode = M_PAUSE; m_sat = 1;
      end else if (c_ss) begin
        case (m_mode)
          M_IDLE:       m_mode = M_RUN;
          M_RUN, M_LAP: m_mode = M_PAUSE;
          default:      if (!m_sat) m_mode = m_snap_ok ? M_LAP : M_RUN;
        endcase
      end else if (c_lap) begin
        case (m_mode)
          M_RUN:   begin m_mode = M_LAP; m_snap = old_time; m_snap_ok = 1; end
          M_LAP:   begin m_mode = M_RUN; m_snap_ok = 0; end
          M_PAUSE: m_snap_ok = 0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic decide();
    bit counting, ok;
    exp_t e;
    c_clr    = h1[1] & ~h2[1];
    c_ss     = h1[0] & ~h2[0] & ~c_clr;
    c_lap    = h1[2] & ~h2[2] & ~c_clr & ~c_ss;
    counting = (m_mode == M_RUN) || (m_mode == M_LAP);
    ok       = counting && (m_frac == TD - 1) && !c_clr && !c_ss;
    c_sat    = AUTOSTOP && ok && (m_time == 3599);
    c_tick   = ok && !c_sat;
    e.hold = c_tick ? 0 : 1;
    e.crst = int'(m_creset);
    e.run  = counting ? 1 : 0;
    e.lap  = (m_mode == M_LAP) ? 1 : 0;
    e.disp = mmss(m_disp);
    sbq.push_back(e);
    drive_time();
  endtask

  task automatic step(input bit [2:0] lv_in);
    @(posedge clock);
    #1;
    edge_update();
    lv = lv_in;
    btn_start_stop = lv_in[0];
    btn_clear      = lv_in[1];
    btn_lap        = lv_in[2];
    decide();
  endtask

  task automatic press(input bit [2:0] which);
    step(which); step(which);
    repeat (4) step(3'b000);
  endtask

  task automatic wait_mode(input int target, input int budget, input string name);
    int n = 0;
    while (m_mode != target && n < budget) begin step(3'b000); n++; end
    if (m_mode != target) check(name, m_mode, target);
  endtask

  task automatic wait_frac(input int target, input string name);
    int n = 0;
    while (m_frac != target && n < 2 * TD) begin step(3'b000); n++; end
    if (m_frac != target) check(name, m_frac, target);
  endtask

  // Monitor: pops one expectation per presented cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!hold_count) dut_ticks++;
      if (counter_reset) crst_cnt++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("hold_count",    int'(hold_count),    e.hold);
        check("counter_reset", int'(counter_reset), e.crst);
        check("running",       int'(running),       e.run);
        check("lap_active",    int'(lap_active),    e.lap);
        check("disp_mmss", int'(disp_minutes) * 100 + int'(disp_seconds), e.disp);
      end
    end
  end

  initial begin
    int t0;
    bit [2:0] rl;
    m_time = 0;
    model_reset();
    #12;
    check("rst_hold_count", int'(hold_count), 1);
    check("rst_counter_reset", int'(counter_reset), 0);
    check("rst_running", int'(running), 0);
    check("rst_lap_active", int'(lap_active), 0);
    check("rst_disp", int'(disp_minutes) * 100 + int'(disp_seconds), 0);
    @(negedge clock);
    reset = 1'b0;

    // Start, then 10 ticks per 40 cycles.
    repeat (2) step(3'b000);
    repeat (3) step(3'b001);
    wait_mode(M_RUN, 10, "wait_run");
    t0 = dut_ticks;
    repeat (40) step(3'b000);
    check("ticks_in_40", dut_ticks - t0, 10);

    // Pause with prescaler at 2, resume keeps the fraction.
    wait_frac(TD - 1, "align_pause");
    repeat (3) step(3'b001);
    t0 = dut_ticks;
    repeat (20) step(3'b000);
    check("no_tick_paused", dut_ticks - t0, 0);
    repeat (3) step(3'b001);
    step(3'b000);
    t0 = dut_ticks;
    step(3'b000);
    check("tick_after_resume", dut_ticks - t0, 1);

    // Lap freeze at 00:07 while live reaches 00:12, then release.
    press(3'b010);
    wait_mode(M_IDLE, 10, "wait_idle_lap");
    repeat (2) step(3'b000);
    m_time = 7;
    drive_time();
    step(3'b001); step(3'b001); step(3'b100); step(3'b100);
    begin
      int n = 0;
      while (m_time != 12 && n < 60) begin step(3'b000); n++; end
      check("reach_0012", m_time, 12);
    end
    check("lap_frozen_disp", int'(disp_minutes) * 100 + int'(disp_seconds), 7);
    check("lap_active_frozen", int'(lap_active), 1);
    press(3'b100);
    check("lap_released", int'(lap_active), 0);

    // start_stop and clear together in RUN: clear wins.
    t0 = crst_cnt;
    press(3'b011);
    check("clear_pulse_count", crst_cnt - t0, 1);
    check("running_after_clear", int'(running), 0);

    // Asynchronous reset mid-prescale.
    press(3'b001);
    wait_frac(1, "align_reset");
    sbq.delete();
    #2;
    reset = 1'b1;
    #1;
    check("async_hold_count", int'(hold_count), 1);
    check("async_running", int'(running), 0);
    check("async_disp", int'(disp_minutes) * 100 + int'(disp_seconds), 0);
    btn_start_stop = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    t0 = dut_ticks;
    repeat (6) step(3'b000);
    check("no_tick_after_reset", dut_ticks - t0, 0);

    // Randomised button traffic.
    rl = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (rl[b]) begin
          if ($urandom_range(0, 2) == 0) rl[b] = 1'b0;
        end else if ($urandom_range(0, (b == 1) ? 40 : 7) == 0) begin
          rl[b] = 1'b1;
        end
      end
      step(rl);
    end
    repeat (4) step(3'b000);

`ifdef STOPWATCH_AUTOSTOP_EN
    press(3'b010);
    repeat (2) step(3'b000);
    m_time = 3598;
    drive_time();
    press(3'b001);
    wait_mode(M_PAUSE, 40, "wait_autostop");
    repeat (3) step(3'b000);
    check("sat_running", int'(running), 0);
    check("sat_disp", int'(disp_minutes) * 100 + int'(disp_seconds), 5959);
    press(3'b001);
    check("sat_start_ignored", int'(running), 0);
    press(3'b010);
    step(3'b000);
    check("sat_cleared_disp", int'(disp_minutes) * 100 + int'(disp_seconds), 0);
`endif

    step(3'b000);
    @(negedge clock);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
